// File: rtl/codec_secded_param_if.sv
// Bus bundle for codec_secded_param: input/output handshakes, data paths,
// error flags and counters. The slave modport is the codec's view, the
// master modport is the view of whatever drives and consumes it.
interface codec_secded_param_if #(
    parameter int ANCHO_DATOS = 4,
    parameter int ANCHO_CONT  = 16
);

    // Smallest R with 2^R >= K + R + 1.
    function automatic int calc_paridad(input int k);
        int r;
        r = 1;
        for (int i = 0; i < 24; i++) begin
            if ((1 << r) < k + r + 1) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int NUM_PARIDAD   = calc_paridad(ANCHO_DATOS);
    localparam int ANCHO_PALABRA = ANCHO_DATOS + NUM_PARIDAD + 1;

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high. The producer holds valid and its payload steady until
    // that edge. Ready may depend on valid, but valid never depends on ready.
    logic                     valido_ent;
    logic                     listo_ent;
    logic                     modo;
    logic [ANCHO_DATOS-1:0]   dato_entrada;
    logic [ANCHO_PALABRA-1:0] palabra_entrada;
    logic                     valido_sal;
    logic                     listo_sal;
    logic [ANCHO_PALABRA-1:0] palabra;
    logic [ANCHO_DATOS-1:0]   dato_salida;
    logic [NUM_PARIDAD-1:0]   sindrome;
    logic                     error_simple;
    logic                     error_doble;
    logic [ANCHO_CONT-1:0]    cont_simple;
    logic [ANCHO_CONT-1:0]    cont_doble;
    logic                     limpiar_cont;

    modport master (
        output valido_ent, modo, dato_entrada, palabra_entrada, listo_sal, limpiar_cont,
        input  listo_ent, valido_sal, palabra, dato_salida, sindrome,
               error_simple, error_doble, cont_simple, cont_doble
    );

    modport slave (
        input  valido_ent, modo, dato_entrada, palabra_entrada, listo_sal, limpiar_cont,
        output listo_ent, valido_sal, palabra, dato_salida, sindrome,
               error_simple, error_doble, cont_simple, cont_doble
    );

endinterface

// File: rtl/codec_secded_param.sv
// Parametrised Hamming SECDED encoder/decoder with a single output register
// stage (latency 1, throughput 1/cycle). Word layout: bit 0 is global parity,
// power-of-two positions hold Hamming parity, the rest hold data in ascending
// order. Optional saturating error counters are built only when the macro
// CODEC_CONTADORES_EN is defined; otherwise they read as zero.
module codec_secded_param #(
    parameter int ANCHO_DATOS = 4,
    parameter int ANCHO_CONT  = 16
) (
    input  logic                 reloj,
    input  logic                 reinicio_n,
    codec_secded_param_if.slave  bus
);

    function automatic int calc_paridad(input int k);
        int r;
        r = 1;
        for (int i = 0; i < 24; i++) begin
            if ((1 << r) < k + r + 1) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int K = ANCHO_DATOS;
    localparam int R = calc_paridad(ANCHO_DATOS);
    localparam int N = K + R + 1;
    localparam int C = ANCHO_CONT;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic valido_q;
    logic listo_ent_w;
    logic fire_ent;

    assign listo_ent_w   = !valido_q || bus.listo_sal;
    assign fire_ent      = bus.valido_ent && listo_ent_w;
    assign bus.listo_ent = listo_ent_w;

    // ------------------------------------------------------------------
    // Data placement and extraction (fixed wiring)
    // ------------------------------------------------------------------
    logic [N-1:0] enc_base;   // data bits in place, parity positions zero
    logic [N-1:0] dec_corr;   // decoded word after any correction
    logic [K-1:0] dec_dato;   // data bits pulled out of dec_corr

    // The data index at a non-power-of-two position p is p minus the number
    // of parity positions at or below p (including bit 0).
    for (genvar p = 0; p < N; p++) begin : g_pos
        if ((p & (p - 1)) == 0) begin : g_par
            assign enc_base[p] = 1'b0;
        end else begin : g_dat
            localparam int IDX = p - $clog2(p + 1) - 1;
            assign enc_base[p]   = bus.dato_entrada[IDX];
            assign dec_dato[IDX] = dec_corr[p];
        end
    end

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic [R-1:0] enc_par;
    logic [N-1:0] enc_w;

    // Hamming parity bits over the data positions, then global parity.
    always_comb begin
        enc_par = '0;
        enc_w   = enc_base;
        for (int i = 0; i < R; i++) begin
            for (int j = 1; j < N; j++) begin
                if (((j >> i) & 1) == 1) begin
                    enc_par[i] = enc_par[i] ^ enc_base[j];
                end
            end
            enc_w[1 << i] = enc_par[i];
        end
        enc_w[0] = ^enc_w[N-1:1];
    end

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    logic [R-1:0] dec_sind;
    logic         dec_pg;
    logic         dec_s_nz;
    logic         dec_s_valida;
    logic         dec_simple;
    logic         dec_doble;

    // Syndrome is the XOR of the indices of all set bits in 1..N-1.
    always_comb begin
        dec_sind = '0;
        for (int j = 1; j < N; j++) begin
            if (bus.palabra_entrada[j]) begin
                dec_sind = dec_sind ^ R'(j);
            end
        end
    end

    assign dec_pg       = ^bus.palabra_entrada;
    assign dec_s_nz     = |dec_sind;
    // A syndrome pointing past the top of the word cannot be a single error.
    assign dec_s_valida = (32'(dec_sind) < 32'(N));
    assign dec_simple   = dec_pg && (!dec_s_nz || dec_s_valida);
    assign dec_doble    = (dec_s_nz && !dec_pg) || (dec_pg && dec_s_nz && !dec_s_valida);

    // Flip the bit the syndrome points at (bit 0 when the syndrome is zero).
    always_comb begin
        dec_corr = bus.palabra_entrada;
        for (int j = 0; j < N; j++) begin
            if (dec_simple && (dec_sind == R'(j))) begin
                dec_corr[j] = ~dec_corr[j];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic         valido_d;
    logic [N-1:0] palabra_d,  palabra_q;
    logic [K-1:0] dato_d,     dato_q;
    logic [R-1:0] sindrome_d, sindrome_q;
    logic         simple_d,   simple_q;
    logic         doble_d,    doble_q;

    // Load on input fire, drop valid on retire, otherwise hold everything.
    always_comb begin
        valido_d   = valido_q;
        palabra_d  = palabra_q;
        dato_d     = dato_q;
        sindrome_d = sindrome_q;
        simple_d   = simple_q;
        doble_d    = doble_q;
        if (fire_ent) begin
            valido_d = 1'b1;
            if (bus.modo) begin
                palabra_d  = dec_corr;
                dato_d     = dec_dato;
                sindrome_d = dec_sind;
                simple_d   = dec_simple;
                doble_d    = dec_doble;
            end else begin
                palabra_d  = enc_w;
                dato_d     = bus.dato_entrada;
                sindrome_d = '0;
                simple_d   = 1'b0;
                doble_d    = 1'b0;
            end
        end else if (bus.listo_sal) begin
            valido_d = 1'b0;
        end
    end

    // Output stage state; reset clears everything and drops any transaction.
    always_ff @(posedge reloj) begin
        if (!reinicio_n) begin
            valido_q   <= 1'b0;
            palabra_q  <= '0;
            dato_q     <= '0;
            sindrome_q <= '0;
            simple_q   <= 1'b0;
            doble_q    <= 1'b0;
        end else begin
            valido_q   <= valido_d;
            palabra_q  <= palabra_d;
            dato_q     <= dato_d;
            sindrome_q <= sindrome_d;
            simple_q   <= simple_d;
            doble_q    <= doble_d;
        end
    end

    assign bus.valido_sal   = valido_q;
    assign bus.palabra      = palabra_q;
    assign bus.dato_salida  = dato_q;
    assign bus.sindrome     = sindrome_q;
    assign bus.error_simple = simple_q;
    assign bus.error_doble  = doble_q;

    // ------------------------------------------------------------------
    // Error counters
    // ------------------------------------------------------------------
`ifdef CODEC_CONTADORES_EN
    logic [C-1:0] cont_simple_d, cont_simple_q;
    logic [C-1:0] cont_doble_d,  cont_doble_q;

    // Saturating increment per decode fire; clear wins over increment.
    always_comb begin
        cont_simple_d = cont_simple_q;
        cont_doble_d  = cont_doble_q;
        if (bus.limpiar_cont) begin
            cont_simple_d = '0;
            cont_doble_d  = '0;
        end else if (fire_ent && bus.modo) begin
            if (dec_simple && !(&cont_simple_q)) begin
                cont_simple_d = cont_simple_q + 1'b1;
            end
            if (dec_doble && !(&cont_doble_q)) begin
                cont_doble_d = cont_doble_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge reloj) begin
        if (!reinicio_n) begin
            cont_simple_q <= '0;
            cont_doble_q  <= '0;
        end else begin
            cont_simple_q <= cont_simple_d;
            cont_doble_q  <= cont_doble_d;
        end
    end

    assign bus.cont_simple = cont_simple_q;
    assign bus.cont_doble  = cont_doble_q;
`else
    // Counters not built: outputs tied low and the clear input is unused.
    logic unused_limpiar;
    assign unused_limpiar  = bus.limpiar_cont;
    assign bus.cont_simple = '0;
    assign bus.cont_doble  = '0;
`endif

endmodule

// File: tb/tb_codec_secded_param.sv
// Directed bench for codec_secded_param: K=4 hand vectors, counter
// saturation/clear, backpressure, K=11 and K=8 flip-injection, mid-stream reset.
module tb_codec_secded_param;

    logic reloj;
    logic reinicio_n;
    int   asrt;
    int   fallos;

    codec_secded_param_if #(.ANCHO_DATOS(4),  .ANCHO_CONT(2))  b4 ();
    codec_secded_param_if #(.ANCHO_DATOS(11), .ANCHO_CONT(16)) b11 ();
    codec_secded_param_if #(.ANCHO_DATOS(8),  .ANCHO_CONT(16)) b8 ();

    codec_secded_param #(.ANCHO_DATOS(4),  .ANCHO_CONT(2))  u4  (.reloj(reloj), .reinicio_n(reinicio_n), .bus(b4));
    codec_secded_param #(.ANCHO_DATOS(11), .ANCHO_CONT(16)) u11 (.reloj(reloj), .reinicio_n(reinicio_n), .bus(b11));
    codec_secded_param #(.ANCHO_DATOS(8),  .ANCHO_CONT(16)) u8  (.reloj(reloj), .reinicio_n(reinicio_n), .bus(b8));

    // Clock
    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

`ifdef CODEC_CONTADORES_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    // Reference encoder built straight from the word-layout description.
    function automatic int np(input int k);
        int r;
        r = 1;
        for (int i = 0; i < 24; i++) if ((1 << r) < k + r + 1) r = r + 1;
        return r;
    endfunction

    function automatic logic [31:0] modelo_cod(input int k, input logic [31:0] d);
        logic [31:0] w;
        int n;
        int di;
        n  = k + np(k) + 1;
        w  = '0;
        di = 0;
        for (int p = 1; p < n; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p] = d[di];
                di++;
            end
        end
        for (int q = 1; q < n; q = q * 2) begin
            logic b;
            b = 1'b0;
            for (int j = 1; j < n; j++) if (((j & q) != 0) && (j != q)) b = b ^ w[j];
            w[q] = b;
        end
        w[0] = ^w;
        return w;
    endfunction

    // Driver tasks: present one transaction, wait one edge, drop valid.
    task automatic drive4(input logic m, input logic [3:0] d, input logic [7:0] w);
        b4.modo = m; b4.dato_entrada = d; b4.palabra_entrada = w; b4.valido_ent = 1'b1;
        @(posedge reloj); #1;
        b4.valido_ent = 1'b0;
    endtask

    task automatic drive11(input logic m, input logic [10:0] d, input logic [15:0] w);
        b11.modo = m; b11.dato_entrada = d; b11.palabra_entrada = w; b11.valido_ent = 1'b1;
        @(posedge reloj); #1;
        b11.valido_ent = 1'b0;
    endtask

    task automatic drive8(input logic m, input logic [7:0] d, input logic [12:0] w);
        b8.modo = m; b8.dato_entrada = d; b8.palabra_entrada = w; b8.valido_ent = 1'b1;
        @(posedge reloj); #1;
        b8.valido_ent = 1'b0;
    endtask

    task automatic test_reset();
        reinicio_n = 1'b0;
        b4.valido_ent = 1'b1; b4.modo = 1'b1; b4.palabra_entrada = 8'hAC;
        b4.listo_sal = 1'b1; b4.limpiar_cont = 1'b0;
        b11.valido_ent = 1'b0; b11.listo_sal = 1'b1; b11.limpiar_cont = 1'b0; b11.modo = 1'b0;
        b11.dato_entrada = '0; b11.palabra_entrada = '0;
        b8.valido_ent = 1'b0; b8.listo_sal = 1'b1; b8.limpiar_cont = 1'b0; b8.modo = 1'b0;
        b8.dato_entrada = '0; b8.palabra_entrada = '0;
        repeat (2) @(posedge reloj);
        #1;
        b4.valido_ent = 1'b0;
        asrt++; if (b4.valido_sal !== 1'b0) begin fallos++; $display("FAIL reset_valido got=%b exp=0", b4.valido_sal); end
        asrt++; if (b4.palabra !== 8'h00) begin fallos++; $display("FAIL reset_palabra got=%h exp=00", b4.palabra); end
        asrt++; if (b4.dato_salida !== 4'h0) begin fallos++; $display("FAIL reset_dato got=%h exp=0", b4.dato_salida); end
        asrt++; if ({b4.sindrome, b4.error_simple, b4.error_doble} !== 5'b0) begin fallos++;
            $display("FAIL reset_flags got=%b exp=0", {b4.sindrome, b4.error_simple, b4.error_doble}); end
        asrt++; if ({b4.cont_simple, b4.cont_doble} !== 4'b0) begin fallos++;
            $display("FAIL reset_cont got=%b exp=0", {b4.cont_simple, b4.cont_doble}); end
        asrt++; if (b4.listo_ent !== 1'b1) begin fallos++; $display("FAIL reset_listo got=%b exp=1", b4.listo_ent); end
        reinicio_n = 1'b1;
        @(posedge reloj); #1;
    endtask

    task automatic test_encode();
        b4.modo = 1'b0; b4.dato_entrada = 4'hB; b4.palabra_entrada = 8'h00; b4.valido_ent = 1'b1;
        asrt++; if (b4.valido_sal !== 1'b0) begin fallos++; $display("FAIL enc_pre_valido got=%b exp=0", b4.valido_sal); end
        @(posedge reloj); #1;
        b4.valido_ent = 1'b0;
        asrt++; if (b4.valido_sal !== 1'b1) begin fallos++; $display("FAIL enc_latencia got=%b exp=1", b4.valido_sal); end
        asrt++; if (b4.palabra !== 8'hAA) begin fallos++; $display("FAIL enc_palabra got=%h exp=aa", b4.palabra); end
        asrt++; if (b4.dato_salida !== 4'hB) begin fallos++; $display("FAIL enc_dato got=%h exp=b", b4.dato_salida); end
        asrt++; if ({b4.sindrome, b4.error_simple, b4.error_doble} !== 5'b0) begin fallos++;
            $display("FAIL enc_flags got=%b exp=0", {b4.sindrome, b4.error_simple, b4.error_doble}); end
        @(posedge reloj); #1;
        asrt++; if (b4.valido_sal !== 1'b0) begin fallos++; $display("FAIL enc_retiro got=%b exp=0", b4.valido_sal); end
    endtask

    task automatic test_decode();
        drive4(1'b1, 4'h0, 8'h8A);
        asrt++; if (b4.sindrome !== 3'd5) begin fallos++; $display("FAIL dec8a_sind got=%0d exp=5", b4.sindrome); end
        asrt++; if (b4.palabra !== 8'hAA) begin fallos++; $display("FAIL dec8a_palabra got=%h exp=aa", b4.palabra); end
        asrt++; if (b4.dato_salida !== 4'hB) begin fallos++; $display("FAIL dec8a_dato got=%h exp=b", b4.dato_salida); end
        asrt++; if ({b4.error_simple, b4.error_doble} !== 2'b10) begin fallos++;
            $display("FAIL dec8a_flags got=%b exp=10", {b4.error_simple, b4.error_doble}); end
        asrt++; if (b4.cont_simple !== (CONT_EN ? 2'd1 : 2'd0)) begin fallos++;
            $display("FAIL dec8a_cont got=%0d exp=%0d", b4.cont_simple, CONT_EN ? 1 : 0); end

        drive4(1'b1, 4'h0, 8'hAB);
        asrt++; if (b4.sindrome !== 3'd0) begin fallos++; $display("FAIL decab_sind got=%0d exp=0", b4.sindrome); end
        asrt++; if (b4.palabra !== 8'hAA) begin fallos++; $display("FAIL decab_palabra got=%h exp=aa", b4.palabra); end
        asrt++; if ({b4.error_simple, b4.error_doble} !== 2'b10) begin fallos++;
            $display("FAIL decab_flags got=%b exp=10", {b4.error_simple, b4.error_doble}); end

        drive4(1'b1, 4'h0, 8'hAC);
        asrt++; if (b4.sindrome !== 3'd3) begin fallos++; $display("FAIL decac_sind got=%0d exp=3", b4.sindrome); end
        asrt++; if (b4.palabra !== 8'hAC) begin fallos++; $display("FAIL decac_palabra got=%h exp=ac", b4.palabra); end
        asrt++; if (b4.dato_salida !== 4'hB) begin fallos++; $display("FAIL decac_dato got=%h exp=b", b4.dato_salida); end
        asrt++; if ({b4.error_simple, b4.error_doble} !== 2'b01) begin fallos++;
            $display("FAIL decac_flags got=%b exp=01", {b4.error_simple, b4.error_doble}); end
        asrt++; if (b4.cont_doble !== (CONT_EN ? 2'd1 : 2'd0)) begin fallos++;
            $display("FAIL decac_cont got=%0d exp=%0d", b4.cont_doble, CONT_EN ? 1 : 0); end

        drive4(1'b1, 4'h0, 8'hAA);
        asrt++; if ({b4.sindrome, b4.error_simple, b4.error_doble, b4.dato_salida} !== {3'd0, 2'b00, 4'hB}) begin fallos++;
            $display("FAIL decaa_limpio got=%b exp=%b", {b4.sindrome, b4.error_simple, b4.error_doble, b4.dato_salida}, {3'd0, 2'b00, 4'hB}); end
    endtask

    task automatic test_saturacion();
        // cont_simple is 2 here when counters exist; five more must stop at 3.
        for (int i = 0; i < 5; i++) drive4(1'b1, 4'h0, 8'h8A);
        asrt++; if (b4.cont_simple !== (CONT_EN ? 2'd3 : 2'd0)) begin fallos++;
            $display("FAIL sat_simple got=%0d exp=%0d", b4.cont_simple, CONT_EN ? 3 : 0); end
        asrt++; if (b4.cont_doble !== (CONT_EN ? 2'd1 : 2'd0)) begin fallos++;
            $display("FAIL sat_doble got=%0d exp=%0d", b4.cont_doble, CONT_EN ? 1 : 0); end
        b4.limpiar_cont = 1'b1;
        drive4(1'b1, 4'h0, 8'h8A);
        b4.limpiar_cont = 1'b0;
        asrt++; if ({b4.cont_simple, b4.cont_doble} !== 4'b0) begin fallos++;
            $display("FAIL limpiar_cont got=%b exp=0", {b4.cont_simple, b4.cont_doble}); end
        asrt++; if (b4.error_simple !== 1'b1) begin fallos++; $display("FAIL limpiar_flag got=%b exp=1", b4.error_simple); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] retenida;
        logic [7:0] esp;
        logic       fire;
        logic       retiro;
        int         entregas;
        // per cycle: valido_ent, dato, listo_sal
        logic       tv [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] td [8] = '{4'h3, 4'h5, 4'h5, 4'h5, 4'h5, 4'h9, 4'h0, 4'h0};
        logic       tl [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        entregas = 0;
        retenida = 8'h00;
        @(posedge reloj); #1;
        for (int c = 0; c < 8; c++) begin
            b4.modo = 1'b0; b4.valido_ent = tv[c]; b4.dato_entrada = td[c]; b4.listo_sal = tl[c];
            #1;
            if (c >= 1 && c <= 3) begin
                asrt++; if (b4.listo_ent !== 1'b0) begin fallos++; $display("FAIL bp_listo c=%0d got=%b exp=0", c, b4.listo_ent); end
                asrt++; if (b4.palabra !== retenida) begin fallos++; $display("FAIL bp_estable c=%0d got=%h exp=%h", c, b4.palabra, retenida); end
            end
            fire   = b4.valido_ent && b4.listo_ent;
            retiro = b4.valido_sal && b4.listo_sal;
            if (retiro) begin
                esp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                entregas++;
                asrt++; if (b4.palabra !== esp) begin fallos++; $display("FAIL bp_orden n=%0d got=%h exp=%h", entregas, b4.palabra, esp); end
            end
            if (fire) begin
                esp = modelo_cod(4, {28'd0, td[c]})[7:0];
                exp_q.push_back(esp);
                if (c == 0) retenida = esp;
            end
            @(posedge reloj); #1;
        end
        asrt++; if (entregas !== 3 || exp_q.size() !== 0) begin fallos++;
            $display("FAIL bp_cuenta got=%0d pend=%0d exp=3 pend=0", entregas, exp_q.size()); end
        b4.listo_sal = 1'b1;
    endtask

    task automatic test_random11();
        logic [10:0] d;
        logic [15:0] cw;
        logic [15:0] w;
        logic [3:0]  s_exp;
        int p1, p2, nf;
        for (int it = 0; it < 12; it++) begin
            d  = 11'($urandom);
            cw = modelo_cod(11, {21'd0, d})[15:0];
            nf = it % 3;
            p1 = $urandom_range(0, 15);
            p2 = (p1 + $urandom_range(1, 15)) % 16;
            drive11(1'b0, d, 16'h0);
            asrt++; if (b11.palabra !== cw) begin fallos++; $display("FAIL r11_enc it=%0d got=%h exp=%h", it, b11.palabra, cw); end
            w = cw; s_exp = 4'd0;
            if (nf >= 1) begin w[p1] = ~w[p1]; s_exp = s_exp ^ 4'(p1); end
            if (nf == 2) begin w[p2] = ~w[p2]; s_exp = s_exp ^ 4'(p2); end
            drive11(1'b1, 11'h0, w);
            asrt++; if ({b11.error_simple, b11.error_doble} !== {nf == 1, nf == 2}) begin fallos++;
                $display("FAIL r11_flags it=%0d nf=%0d got=%b", it, nf, {b11.error_simple, b11.error_doble}); end
            asrt++; if (b11.sindrome !== s_exp) begin fallos++; $display("FAIL r11_sind it=%0d got=%0d exp=%0d", it, b11.sindrome, s_exp); end
            asrt++; if (b11.palabra !== ((nf == 2) ? w : cw)) begin fallos++;
                $display("FAIL r11_palabra it=%0d got=%h exp=%h", it, b11.palabra, (nf == 2) ? w : cw); end
            if (nf < 2) begin
                asrt++; if (b11.dato_salida !== d) begin fallos++; $display("FAIL r11_dato it=%0d got=%h exp=%h", it, b11.dato_salida, d); end
            end
        end
    endtask

    task automatic test_random8();
        logic [7:0]  d;
        logic [12:0] cw;
        logic [12:0] w;
        logic [3:0]  s_exp;
        int p1, p2, nf;
        for (int it = 0; it < 12; it++) begin
            d  = 8'($urandom);
            cw = modelo_cod(8, {24'd0, d})[12:0];
            nf = it % 3;
            p1 = $urandom_range(0, 12);
            p2 = (p1 + $urandom_range(1, 12)) % 13;
            drive8(1'b0, d, 13'h0);
            asrt++; if (b8.palabra !== cw) begin fallos++; $display("FAIL r8_enc it=%0d got=%h exp=%h", it, b8.palabra, cw); end
            w = cw; s_exp = 4'd0;
            if (nf >= 1) begin w[p1] = ~w[p1]; s_exp = s_exp ^ 4'(p1); end
            if (nf == 2) begin w[p2] = ~w[p2]; s_exp = s_exp ^ 4'(p2); end
            drive8(1'b1, 8'h0, w);
            asrt++; if ({b8.error_simple, b8.error_doble} !== {nf == 1, nf == 2}) begin fallos++;
                $display("FAIL r8_flags it=%0d nf=%0d got=%b", it, nf, {b8.error_simple, b8.error_doble}); end
            asrt++; if (b8.sindrome !== s_exp) begin fallos++; $display("FAIL r8_sind it=%0d got=%0d exp=%0d", it, b8.sindrome, s_exp); end
            if (nf < 2) begin
                asrt++; if (b8.dato_salida !== d) begin fallos++; $display("FAIL r8_dato it=%0d got=%h exp=%h", it, b8.dato_salida, d); end
            end
        end
        // Three flips on the all-zero codeword: syndrome 15 lies past bit 12.
        drive8(1'b1, 8'h0, 13'h1006);
        asrt++; if ({b8.sindrome, b8.error_simple, b8.error_doble} !== {4'd15, 2'b01}) begin fallos++;
            $display("FAIL r8_fuera_rango got=%b exp=%b", {b8.sindrome, b8.error_simple, b8.error_doble}, {4'd15, 2'b01}); end
        asrt++; if (b8.palabra !== 13'h1006) begin fallos++; $display("FAIL r8_fuera_palabra got=%h exp=1006", b8.palabra); end
    endtask

    task automatic test_reset_medio();
        b11.modo = 1'b0; b11.dato_entrada = 11'h5A5; b11.valido_ent = 1'b1; b11.listo_sal = 1'b1;
        repeat (2) @(posedge reloj);
        #1;
        asrt++; if (b11.valido_sal !== 1'b1) begin fallos++; $display("FAIL rm_flujo got=%b exp=1", b11.valido_sal); end
        reinicio_n = 1'b0;
        @(posedge reloj); #1;
        asrt++; if (b11.valido_sal !== 1'b0) begin fallos++; $display("FAIL rm_valido got=%b exp=0", b11.valido_sal); end
        asrt++; if (b11.palabra !== 16'h0) begin fallos++; $display("FAIL rm_palabra got=%h exp=0", b11.palabra); end
        b11.valido_ent = 1'b0;
        reinicio_n = 1'b1;
        @(posedge reloj); #1;
        asrt++; if (b11.valido_sal !== 1'b0) begin fallos++; $display("FAIL rm_descartado got=%b exp=0", b11.valido_sal); end
    endtask

    initial begin
        asrt = 0;
        fallos = 0;
        test_reset();
        test_encode();
        test_decode();
        test_saturacion();
        test_back_to_back();
        test_random11();
        test_random8();
        test_reset_medio();
        $display("End of test - %0d assertions evaluated, %0d failures", asrt, fallos);
        $finish;
    end

endmodule
